// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide 8N1 UART transmitter fed by a small circular-buffer FIFO.
// Ports: clk/rst (sync, active-high); tx_data/tx_valid/tx_ready byte push handshake;
//        tx serial line (idle high); busy (frame in flight or bytes queued); fifo_count (queued bytes).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] FULL      = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   baud_cnt, baud_nxt;
  logic [2:0]      bit_idx, bit_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            tx_nxt;
  logic            pop;
  logic            push;
  logic            baud_last;
  logic            fifo_empty;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;

  assign tx_ready   = (fifo_count != FULL);
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (fifo_count == '0);
  assign busy       = (state != IDLE) || !fifo_empty;
  assign baud_last  = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    pop       = 1'b0;
    tx_nxt    = 1'b1;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          baud_nxt  = '0;
          state_nxt = START;
        end
      end
      START: begin
        baud_nxt = baud_last ? '0 : baud_cnt + 1'b1;
        if (baud_last) begin
          bit_nxt   = 3'd0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        baud_nxt = baud_last ? '0 : baud_cnt + 1'b1;
        if (baud_last) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt   = bit_idx + 3'd1;
            shift_nxt = {1'b0, shift[7:1]};
          end
        end
      end
      STOP: begin
        baud_nxt = baud_last ? '0 : baud_cnt + 1'b1;
        if (baud_last) begin
          // Chain straight into the next start bit so queued frames are contiguous.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // tx is derived from the next state so the pin itself is a flop.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-wide UART transmitter with a small input FIFO. Serialises 8N1 frames onto the tx pin.
- It is the return direction of the UART RGB design: echoes or reports RGB command bytes back to the host.
- It is also the stimulus source benches use to drive the receiver end-to-end.
- Upstream logic pushes bytes with a valid/ready handshake. The block paces output at a fixed bit period.

Parameters:
- CLKS_PER_BIT, 104: clock cycles per UART bit (12 MHz / 115200). Legal range ≥2.
- FIFO_DEPTH, 4: number of byte entries in the input FIFO. Must be a power of two, ≥2.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tx_data  input  8  byte to send
- tx_valid  input  1  tx_data is valid this cycle
- tx_ready  output  1  FIFO can accept a byte this cycle (= not full)
- tx  output  1  serial line; idle high
- busy  output  1  high while a frame is in flight or FIFO non-empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued (excludes the byte in the shifter)

Behaviour:
- Reset (rst high at an edge) sets: tx=1, tx_ready=1, busy=0, fifo_count=0, FSM=IDLE, bit and baud counters=0, FIFO pointers=0.
- Reset applies on the next edge even mid-frame. The partially sent frame is abandoned and tx returns high immediately. FIFO contents are discarded.
- Handshake:
  - A byte is accepted at an edge where tx_valid && tx_ready.
  - tx_valid with tx_ready low is ignored; nothing is captured.
  - tx_data need not be held after acceptance.
- tx_ready = (fifo_count != FIFO_DEPTH). It is combinational from registered count.
- FIFO: circular buffer with wrapping read/write pointers.
  - Push and pop at the same edge leave fifo_count unchanged.
  - Pop never occurs on an empty FIFO.
  - Push never occurs when full.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count≠0, pop the head into an 8-bit shift register and go to START.
  - START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle of STOP:
    - if FIFO non-empty, pop and go directly to START (no idle gap);
    - else go to IDLE.
- Frame length: exactly 10×CLKS_PER_BIT cycles. tx is registered, so there are no glitches between bits.
- Latency: for a byte accepted at edge E into an empty, idle block, FSM pops at edge E+1 and tx goes low after edge E+1.
- Back-to-back: consecutive queued bytes produce contiguous frames. The stop bit is immediately followed by the next start bit.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. It is cleared on entry to START from IDLE.
- busy = (state≠IDLE) || (fifo_count≠0).
- Capacity: in steady transmission, FIFO_DEPTH bytes are queued plus one in the shifter.

Test Plan:
Benches use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
1. Reset: rst held 3 cycles then released → tx=1, tx_ready=1, busy=0, fifo_count=0. tx stays high 50 cycles with no valid.
2. Single byte 0x41 pushed at edge E:
   - tx low after E+1;
   - line sequence 0,1,0,0,0,0,0,1,0,1, each held 4 cycles (40 total);
   - busy falls on the cycle tx returns to idle after stop.
3. Back-to-back 0x52,0x47,0x42 on consecutive cycles → fifo_count peaks at 2 (first popped at E+1). Three frames occupy 120 contiguous cycles. No high gap longer than one stop bit. Decoded bytes are R,G,B in order.
4. Fill: hold tx_valid with bytes 0x01..0x06 → 0x01 enters shifter; 0x02..0x05 fill FIFO; tx_ready=0 with fifo_count=4. 0x06 is accepted only after the 0x02 pop. Output order is 0x01..0x06 with none lost or duplicated.
5. Reset mid-frame: push 0x55, assert rst during data bit 3 → tx=1 after that edge, fifo_count=0, busy=0. Then push 0xAA → clean frame 0,0,1,0,1,0,1,0,1,1.
6. Valid while full: keep tx_valid high with changing tx_data while tx_ready=0 → no byte captured during those cycles. fifo_count never exceeds 4.
